watchdog_multi: RTL and testbench

- Parametrised successor to the single-channel watchdog_timer.
- Supervises N_CH independent heartbeat sources. Each channel has its own programmable timeout and warning thresholds, a per-channel enable, sticky trip flags and software clear.
- Any channel trip produces one shared, fixed-length force_reset pulse toward the system reset controller.
- Sits beside the AM-radio control/DSP cores.

---
 rtl/watchdog_pkg.sv | 20 ++
 rtl/watchdog_multi_if.sv | 15 +
 rtl/watchdog_channel.sv | 140 ++++++++++++++
 rtl/watchdog_multi.sv | 94 +++++++++
 tb/tb_watchdog_multi.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/watchdog_pkg.sv
// Shared types and helpers for the multi-channel watchdog.
package watchdog_pkg;

  typedef enum logic [1:0] {
    DISABLED = 2'd0,
    RUNNING  = 2'd1,
    WARN     = 2'd2,
    TRIPPED  = 2'd3
  } wd_ch_state_e;

  typedef enum logic {
    IDLE  = 1'b0,
    PULSE = 1'b1
  } wd_pulse_state_e;

  function automatic int cnt_width(input int max_val);
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/watchdog_multi_if.sv
// Control/status bundle between the watchdog and its supervisor.
interface watchdog_multi_if #(parameter int N_CH = 2);
  logic [N_CH-1:0] enable;
  logic [N_CH-1:0] heartbeat;
  logic [N_CH-1:0] clear;
  logic [N_CH-1:0] warning;
  logic [N_CH-1:0] triggered;
  logic [N_CH-1:0] early_kick;
  logic            force_reset;

  modport master (output enable, heartbeat, clear,
                  input  warning, triggered, early_kick, force_reset);
  modport slave  (input  enable, heartbeat, clear,
                  output warning, triggered, early_kick, force_reset);
endinterface

// File: rtl/watchdog_channel.sv
// One supervised heartbeat channel: edge detect, age counter, trip FSM.
// Windowed early-kick detection is built only with WATCHDOG_WINDOW_EN.
//
// state    | meaning
// DISABLED | channel off, counter held at 0
// RUNNING  | counting, below the warning threshold
// WARN     | counting, at or above the warning threshold
// TRIPPED  | timeout or early kick seen, frozen until clear
module watchdog_channel
  import watchdog_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int WARN_CYCLES    = 750000,
  parameter int WINDOW_MIN     = 1000
) (
  input  logic clk,
  input  logic rstn,
  input  logic enable,
  input  logic heartbeat,
  input  logic clear,
  output logic warning,
  output logic triggered,
  output logic early_kick
);
  localparam int CW = cnt_width(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] TIMEOUT_VAL = CW'(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] WARN_VAL    = CW'(WARN_CYCLES);

  if (WARN_CYCLES >= TIMEOUT_CYCLES) begin : g_bad_warn
    $fatal(1, "watchdog_channel: WARN_CYCLES must be below TIMEOUT_CYCLES");
  end
  if (WINDOW_MIN >= WARN_CYCLES) begin : g_bad_window
    $fatal(1, "watchdog_channel: WINDOW_MIN must be below WARN_CYCLES");
  end

  wd_ch_state_e   state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d, cnt_inc;
  logic           hb_q;
  logic           kick;

  assign kick    = heartbeat & ~hb_q;
  assign cnt_inc = cnt_q + CW'(1);

`ifdef WATCHDOG_WINDOW_EN
  localparam logic [CW-1:0] WIN_VAL = CW'(WINDOW_MIN);
  logic first_q, first_d, early_q, early_d;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
`ifdef WATCHDOG_WINDOW_EN
    first_d = first_q;
    early_d = early_q;
`endif
    case (state_q)
      DISABLED: begin
        cnt_d = '0;
        if (enable) begin
          state_d = RUNNING;
`ifdef WATCHDOG_WINDOW_EN
          first_d = 1'b1;
`endif
        end
      end
      RUNNING, WARN: begin
        if (!enable) begin
          state_d = DISABLED;
          cnt_d   = '0;
        end else if (kick) begin
`ifdef WATCHDOG_WINDOW_EN
          // The first kick after (re)arming has no reference point, so it is exempt.
          if (state_q == RUNNING && !first_q && cnt_q < WIN_VAL) begin
            state_d = TRIPPED;
            early_d = 1'b1;
          end else begin
            state_d = RUNNING;
            cnt_d   = '0;
            first_d = 1'b0;
          end
`else
          state_d = RUNNING;
          cnt_d   = '0;
`endif
        end else if (cnt_inc == TIMEOUT_VAL) begin
          state_d = TRIPPED;
          cnt_d   = cnt_inc;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == WARN_VAL) state_d = WARN;
        end
      end
      TRIPPED: begin
        if (clear) begin
          state_d = enable ? RUNNING : DISABLED;
          cnt_d   = '0;
`ifdef WATCHDOG_WINDOW_EN
          early_d = 1'b0;
          first_d = 1'b1;
`endif
        end
      end
      default: begin
        state_d = DISABLED;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= DISABLED;
      cnt_q   <= '0;
      hb_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hb_q    <= heartbeat;
    end
  end

`ifdef WATCHDOG_WINDOW_EN
  always_ff @(posedge clk) begin
    if (!rstn) begin
      first_q <= 1'b0;
      early_q <= 1'b0;
    end else begin
      first_q <= first_d;
      early_q <= early_d;
    end
  end
  assign early_kick = early_q;
`else
  assign early_kick = 1'b0;
`endif

  assign warning   = (state_q == WARN);
  assign triggered = (state_q == TRIPPED);

endmodule

// File: rtl/watchdog_multi.sv
// N_CH-channel watchdog with one shared fixed-length force_reset pulse.
// Optional windowed kick checking is enabled by defining WATCHDOG_WINDOW_EN.
//
// state | meaning
// IDLE  | waiting for a new channel trip
// PULSE | driving force_reset for RST_PULSE cycles
module watchdog_multi
  import watchdog_pkg::*;
#(
  parameter int N_CH           = 2,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int WARN_CYCLES    = 750000,
  parameter int WINDOW_MIN     = 1000,
  parameter int RST_PULSE      = 16
) (
  input logic              clk,
  input logic              rstn,
  watchdog_multi_if.slave  bus
);
  localparam int PW = cnt_width(RST_PULSE);

  if (N_CH < 1 || N_CH > 8) begin : g_bad_nch
    $fatal(1, "watchdog_multi: N_CH must be within 1..8");
  end
  if (TIMEOUT_CYCLES < 4) begin : g_bad_timeout
    $fatal(1, "watchdog_multi: TIMEOUT_CYCLES must be at least 4");
  end
  if (RST_PULSE < 1) begin : g_bad_pulse
    $fatal(1, "watchdog_multi: RST_PULSE must be at least 1");
  end

  logic [N_CH-1:0] warn_v, trig_v, early_v, trig_q;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    watchdog_channel #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
      .WARN_CYCLES    (WARN_CYCLES),
      .WINDOW_MIN     (WINDOW_MIN)
    ) u_ch (
      .clk        (clk),
      .rstn       (rstn),
      .enable     (bus.enable[i]),
      .heartbeat  (bus.heartbeat[i]),
      .clear      (bus.clear[i]),
      .warning    (warn_v[i]),
      .triggered  (trig_v[i]),
      .early_kick (early_v[i])
    );
  end

  assign bus.warning    = warn_v;
  assign bus.triggered  = trig_v;
  assign bus.early_kick = early_v;

  wd_pulse_state_e pst_q, pst_d;
  logic [PW-1:0]   pcnt_q, pcnt_d;
  logic            trip_rise;

  // Per-channel edge so a second channel tripping later still counts as new.
  assign trip_rise = |(trig_v & ~trig_q);

  always_comb begin
    pst_d  = pst_q;
    pcnt_d = pcnt_q;
    case (pst_q)
      IDLE: begin
        if (trip_rise) begin
          pst_d  = PULSE;
          pcnt_d = PW'(RST_PULSE - 1);
        end
      end
      PULSE: begin
        if (pcnt_q == '0) pst_d = IDLE;
        else              pcnt_d = pcnt_q - PW'(1);
      end
      default: pst_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      pst_q  <= IDLE;
      pcnt_q <= '0;
      trig_q <= '0;
    end else begin
      pst_q  <= pst_d;
      pcnt_q <= pcnt_d;
      trig_q <= trig_v;
    end
  end

  assign bus.force_reset = (pst_q == PULSE);

endmodule

// File: tb/tb_watchdog_multi.sv
// Directed and randomized checks of watchdog_multi against a cycle-age model.
module tb_watchdog_multi;
  localparam int N_CH = 2;
  localparam int TO   = 16;
  localparam int WN   = 12;
  localparam int WMIN = 4;
  localparam int RP   = 3;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  watchdog_multi_if #(.N_CH(N_CH)) bus ();

  watchdog_multi #(
    .N_CH(N_CH), .TIMEOUT_CYCLES(TO), .WARN_CYCLES(WN),
    .WINDOW_MIN(WMIN), .RST_PULSE(RP)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int    n_cmp = 0;
  int    n_bad = 0;
  string phase = "init";

  // Model: age = cycles since arming or last accepted kick.
  int age       [N_CH];
  bit on        [N_CH];
  bit trip      [N_CH];
  bit early     [N_CH];
  bit first     [N_CH];
  bit hb_prev   [N_CH];
  bit rose_last;
  int pulse_left;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s/%s: got %0h expected %0h at %0t", phase, tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge(input bit r, input logic [N_CH-1:0] en, hb, clr);
    bit new_rose;
    bit kick;
    new_rose = 1'b0;
    if (!r) begin
      for (int i = 0; i < N_CH; i++) begin
        age[i] = 0; on[i] = 0; trip[i] = 0; early[i] = 0; first[i] = 0; hb_prev[i] = 0;
      end
      rose_last  = 1'b0;
      pulse_left = 0;
      return;
    end
    if (pulse_left > 0)  pulse_left--;
    else if (rose_last)  pulse_left = RP;
    for (int i = 0; i < N_CH; i++) begin
      kick = hb[i] && !hb_prev[i];
      if (trip[i]) begin
        if (clr[i]) begin
          trip[i] = 0; early[i] = 0; age[i] = 0; on[i] = en[i]; first[i] = 1;
        end
      end else if (!on[i]) begin
        if (en[i]) begin
          on[i] = 1; age[i] = 0; first[i] = 1;
        end
      end else if (!en[i]) begin
        on[i] = 0; age[i] = 0;
      end else if (kick) begin
`ifdef WATCHDOG_WINDOW_EN
        if (!first[i] && age[i] < WMIN) begin
          trip[i] = 1; early[i] = 1; new_rose = 1;
        end else begin
          age[i] = 0; first[i] = 0;
        end
`else
        age[i] = 0;
`endif
      end else if (age[i] + 1 >= TO) begin
        trip[i] = 1; new_rose = 1;
      end else begin
        age[i]++;
      end
      hb_prev[i] = hb[i];
    end
    rose_last = new_rose;
  endtask

  task automatic check_model();
    logic [N_CH-1:0] ew, et, ee;
    for (int i = 0; i < N_CH; i++) begin
      ew[i] = on[i] && !trip[i] && age[i] >= WN;
      et[i] = trip[i];
      ee[i] = early[i];
    end
    chk("warning",     8'(bus.warning),     8'(ew));
    chk("triggered",   8'(bus.triggered),   8'(et));
    chk("early_kick",  8'(bus.early_kick),  8'(ee));
    chk("force_reset", 8'(bus.force_reset), 8'(pulse_left > 0));
  endtask

  task automatic cycle(input bit r, input logic [N_CH-1:0] en, hb, clr);
    @(negedge clk);
    rstn          = r;
    bus.enable    = en;
    bus.heartbeat = hb;
    bus.clear     = clr;
    @(posedge clk);
    model_edge(r, en, hb, clr);
    #1;
    check_model();
  endtask

  task automatic do_reset(input logic [N_CH-1:0] en);
    cycle(1'b0, en, '0, '0);
    cycle(1'b0, en, '0, '0);
    chk("rst_warning",   8'(bus.warning),     8'h0);
    chk("rst_triggered", 8'(bus.triggered),   8'h0);
    chk("rst_force",     8'(bus.force_reset), 8'h0);
  endtask

  logic [7:0]      seen;
  logic [N_CH-1:0] r_en, r_hb, r_clr;
  bit              r_rst;

  initial begin
    bus.enable = '0; bus.heartbeat = '0; bus.clear = '0;

    phase = "s1_no_kick";
    do_reset(2'b11);
    for (int c = 0; c <= 24; c++) begin
      cycle(1'b1, 2'b11, 2'b00, 2'b00);
      if (c == 11) chk("warn_c11", 8'(bus.warning), 8'h0);
      if (c == 12) chk("warn_c12", 8'(bus.warning), 8'h3);
      if (c == 16) begin
        chk("trig_c16", 8'(bus.triggered), 8'h3);
        chk("warn_c16", 8'(bus.warning), 8'h0);
      end
      chk("pulse_win", 8'(bus.force_reset), 8'((c >= 17) && (c <= 19)));
    end

    phase = "s2_kicked";
    do_reset(2'b01);
    seen = '0;
    for (int c = 0; c < 200; c++) begin
      cycle(1'b1, 2'b01, 2'((c % 10 == 0) && (c > 0)), 2'b00);
      seen = seen | 8'({bus.warning, bus.triggered, bus.force_reset});
    end
    chk("quiet", seen, 8'h0);

    phase = "s3_late_kick";
    do_reset(2'b01);
    for (int c = 0; c <= 30; c++) begin
      cycle(1'b1, 2'b01, 2'(c == 16), 2'b00);
      if (c == 15) chk("warn_c15", 8'(bus.warning), 8'h1);
      if (c == 16) begin
        chk("trig_c16", 8'(bus.triggered), 8'h0);
        chk("warn_c16", 8'(bus.warning), 8'h0);
      end
      if (c == 27) chk("warn_c27", 8'(bus.warning), 8'h0);
      if (c == 28) chk("warn_c28", 8'(bus.warning), 8'h1);
    end

    phase = "s4_window";
    do_reset(2'b01);
    for (int c = 0; c <= 20; c++) begin
      cycle(1'b1, 2'b01, 2'((c == 6) || (c == 9)), 2'b00);
      if (c == 9) begin
`ifdef WATCHDOG_WINDOW_EN
        chk("early_c9", 8'(bus.early_kick), 8'h1);
        chk("trig_c9",  8'(bus.triggered),  8'h1);
`else
        chk("early_c9", 8'(bus.early_kick), 8'h0);
        chk("trig_c9",  8'(bus.triggered),  8'h0);
`endif
      end
`ifdef WATCHDOG_WINDOW_EN
      chk("pulse_win", 8'(bus.force_reset), 8'((c >= 10) && (c <= 12)));
`else
      chk("no_pulse", 8'(bus.force_reset), 8'h0);
`endif
    end

    phase = "s5_two_trips";
    do_reset(2'b00);
    for (int c = 0; c <= 33; c++) begin
      cycle(1'b1, (c == 0) ? 2'b01 : 2'b11, 2'b00, 2'(c == 20));
      chk("pulse_win", 8'(bus.force_reset), 8'((c >= 17) && (c <= 19)));
      if (c == 17) chk("trig_c17", 8'(bus.triggered), 8'h3);
      if (c >= 20) chk("trig_after_clr", 8'(bus.triggered), 8'h2);
      if (c == 31) chk("warn0_c31", 8'(bus.warning[0]), 8'h0);
      if (c == 32) chk("warn0_c32", 8'(bus.warning[0]), 8'h1);
    end

    phase = "s6_reset_mid_pulse";
    do_reset(2'b11);
    for (int c = 0; c <= 33; c++) begin
      cycle(c != 19, 2'b11, 2'b00, 2'b00);
      if (c == 18) chk("pulse_c18", 8'(bus.force_reset), 8'h1);
      if (c == 19) begin
        chk("force_c19", 8'(bus.force_reset), 8'h0);
        chk("trig_c19",  8'(bus.triggered),   8'h0);
        chk("warn_c19",  8'(bus.warning),     8'h0);
      end
      if (c == 31) chk("warn_c31", 8'(bus.warning), 8'h0);
      if (c == 32) chk("warn_c32", 8'(bus.warning), 8'h3);
    end

    phase = "random";
    do_reset(2'b11);
    r_en = 2'b11;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 39) == 0) r_en[$urandom_range(0, N_CH-1)] ^= 1'b1;
      for (int i = 0; i < N_CH; i++) begin
        r_hb[i]  = ($urandom_range(0, 9) < 2);
        r_clr[i] = ($urandom_range(0, 7) == 0);
      end
      r_rst = ($urandom_range(0, 599) != 0);
      cycle(r_rst, r_en, r_hb, r_clr);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
